gift_perm_addkey_stage: RTL and testbench
=========================================

GIFT_PERM_ADDKEY_STAGE -- requirements
Module: gift_perm_addkey_stage

Interface
REQ-001 The block SHALL have a parameter ROUNDS, default 40, giving the number of GIFT-128 rounds per block.
REQ-002 The block SHALL have a single clock `clk` and an asynchronous, active-low reset `rstN`; all state SHALL use this clock and reset.
REQ-003 Ports SHALL be, one per line, name direction width meaning:
- clk  in  1  rising-edge clock
- rstN  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: load keyIn, begin a new block
- keyIn  in  128  master key K = k7||...||k0, 16-bit words, k7 = [127:112]
- inValid  in  1  inData valid
- inData  in  128  SubCells output for the current round
- inReady  out  1  stage can accept inData
- outValid  out  1  outData valid
- outData  out  128  PermBits + AddRoundKey + constant result
- outReady  in  1  consumer accepts outData
- roundIdx  out  6  rounds accepted since start (0..ROUNDS)
- lastRound  out  1  outData is the final-round result
- busy  out  1  state is not IDLE

Function
REQ-004 States SHALL be IDLE, RUN and DRAIN.
- IDLE: inReady=0; start loads keyReg=keyIn, constReg=6'h00, roundIdx=0, then goes to RUN.
REQ-005 In RUN, inReady SHALL equal (!outValid || outReady); a transfer occurs when inValid && inReady.
REQ-006 On a transfer, the next constant c' = {c[4:0], c[5]^c[4]^1} SHALL be formed from constReg; the first round uses 6'h01.
REQ-007 On a transfer, outData SHALL be registered as X = P(inData) ^ roundkey ^ constant, where P moves bit i to 4*floor(i/16) + 32*((3*floor((i%16)/4) + (i%4)) % 4) + (i%4).
REQ-008 The round key SHALL take U = k5||k4 and V = k1||k0 from keyReg, and for i = 0..31 XOR bit 4i+2 with U[i] and bit 4i+1 with V[i].
REQ-009 The constant SHALL XOR c'[5:0] into bits 23, 19, 15, 11, 7, 3 respectively, and XOR 1 into bit 127.
REQ-010 On a transfer, the block SHALL also:
- set outValid=1;
- update constReg=c';
- update keyReg = (k1>>>2)||(k0>>>12)||k7||k6||k5||k4||k3||k2, where >>> is a 16-bit rotate right;
- increment roundIdx.
REQ-011 lastRound SHALL be registered with outData and SHALL be 1 only for the transfer at roundIdx==ROUNDS-1; that transfer SHALL move the state to DRAIN.
REQ-012 In DRAIN, inReady SHALL be 0; when outValid && outReady, the state SHALL go to IDLE.
REQ-013 Output handshake rules:
- outValid && outReady without a same-cycle transfer SHALL clear outValid.
- A same-cycle take and transfer SHALL keep outValid=1 with new data (full throughput, one round per cycle).
- While outValid && !outReady, outData and lastRound SHALL hold stable.
REQ-014 start in RUN or DRAIN SHALL be ignored.
REQ-015 start in IDLE in the same cycle as inValid SHALL perform no transfer that cycle.
REQ-016 inData SHALL be ignored whenever inReady=0.

Reset
REQ-017 Asserting rstN=0 SHALL immediately force state=IDLE, outValid=0, lastRound=0, roundIdx=0, busy=0, keyReg=0, constReg=0 and outData=0, regardless of any block in flight.
REQ-018 An aborted block SHALL leave no residue; the next start SHALL behave as after power-up.

Verification
REQ-019 Key 0, start, then inData=128'h1111...1111 on cycle 1 -> outData=128'h91111111_11111111_11111111_11111119 one cycle later, roundIdx=1, lastRound=0.
REQ-020 Loop outData through the SubCells stage back to inData, plaintext 0 and key 0, ROUNDS=40 -> 40th output = 128'hCD0BD738388AD3F668B15A36CEB6FF92 with lastRound=1, then IDLE.
REQ-021 Constants over 40 transfers -> sequence 01,03,07,0F,1F,3E,3D,3B,37,2F,...; keyReg after one transfer with keyIn = 128'h0001_..._0001 (all words 1) -> k7 = 16'h4000, k6 = 16'h0010, k5..k0 = 16'h0001.
REQ-022 Hold outReady=0 for 5 cycles with outValid=1 -> inReady=0, outData stable, no key or constant advance; release -> one transfer per cycle resumes.
REQ-023 Pulse rstN low at round 17 -> all outputs reset asynchronously; a new start with the REQ-020 stimulus gives the correct ciphertext.
REQ-024 start pulsed mid-RUN and inValid asserted in IDLE and DRAIN -> no state, key or output change.

Source files
------------

// File: rtl/gift_perm_addkey_stage.sv
// GIFT-128 round back half: bit permutation, round-key addition and round
// constant, with a ready/valid output register and the on-the-fly key schedule.
// An upstream SubCells stage feeds inData, and a one-cycle start pulse begins
// a new block. With a consumer that never stalls, the stage completes one
// round per cycle.
module gift_perm_addkey_stage #(
  parameter int ROUNDS = 40
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         start,
  input  logic [127:0] keyIn,
  input  logic         inValid,
  input  logic [127:0] inData,
  output logic         inReady,
  output logic         outValid,
  output logic [127:0] outData,
  input  logic         outReady,
  output logic [5:0]   roundIdx,
  output logic         lastRound,
  output logic         busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic [127:0] r_key;
  logic [5:0]   r_const;
  logic [5:0]   r_round_idx;
  logic         r_out_valid;
  logic [127:0] r_out_data;
  logic         r_last_round;

  logic         w_load;
  logic         w_xfer;
  logic         w_take;
  logic         w_last;
  logic [5:0]   w_const_next;
  logic [127:0] w_perm;
  logic [127:0] w_round_key;
  logic [127:0] w_const_mask;
  logic [127:0] w_result;
  logic [127:0] w_key_next;
  logic [31:0]  w_u;
  logic [31:0]  w_v;

  // Handshake terms. The stage accepts a round only while running and only
  // when the output register is empty or is being drained in the same cycle.
  assign inReady = (r_state == ST_RUN) && (!r_out_valid || outReady);
  assign w_load  = (r_state == ST_IDLE) && start;
  assign w_xfer  = inValid && inReady;
  assign w_take  = r_out_valid && outReady;
  assign w_last  = (r_round_idx == 6'(ROUNDS - 1));

  // PermBits: bit i of the SubCells output moves to the GIFT-128 position.
  // The mapping is a bijection, so every bit of w_perm has exactly one driver.
  for (genvar gi = 0; gi < 128; gi++) begin : g_perm
    localparam int DST = 4 * (gi / 16) + 32 * ((3 * ((gi % 16) / 4) + (gi % 4)) % 4) + (gi % 4);
    assign w_perm[DST] = inData[gi];
  end

  // Round key: U = k5||k4 goes into bit 2 of every nibble, V = k1||k0 into bit 1.
  assign w_u = r_key[95:64];
  assign w_v = r_key[31:0];
  for (genvar gj = 0; gj < 32; gj++) begin : g_round_key
    assign w_round_key[4*gj+3] = 1'b0;
    assign w_round_key[4*gj+2] = w_u[gj];
    assign w_round_key[4*gj+1] = w_v[gj];
    assign w_round_key[4*gj]   = 1'b0;
  end

  // The 6-bit LFSR constant advances before use, so the first round sees 6'h01.
  assign w_const_next = {r_const[4:0], r_const[5] ^ r_const[4] ^ 1'b1};

  // Build the constant mask: c' lands on bits 23..3 in steps of 4, plus bit 127.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_const_mask      = '0;
    w_const_mask[127] = 1'b1;
    w_const_mask[23]  = w_const_next[5];
    w_const_mask[19]  = w_const_next[4];
    w_const_mask[15]  = w_const_next[3];
    w_const_mask[11]  = w_const_next[2];
    w_const_mask[7]   = w_const_next[1];
    w_const_mask[3]   = w_const_next[0];
  end

  assign w_result = w_perm ^ w_round_key ^ w_const_mask;

  // Key schedule: new key = (k1>>>2)||(k0>>>12)||k7||k6||k5||k4||k3||k2.
  assign w_key_next = {r_key[17:16], r_key[31:18],   // k1 rotated right by 2
                       r_key[11:0],  r_key[15:12],   // k0 rotated right by 12
                       r_key[127:32]};               // k7..k2 shift down two words

  // Next-state logic for the block sequencer.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_next = ST_RUN;
      ST_RUN:   if (w_xfer && w_last) w_state_next = ST_DRAIN;
      ST_DRAIN: if (w_take) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstN) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rstN) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Key, constant and round counter: loaded by start, advanced once per accepted round.
  always_ff @(posedge clk or negedge rstN) begin
    // NOTE: the key register is reset too, so an aborted block leaves no key material behind.
    if (!rstN) begin
      r_key       <= '0;
      r_const     <= '0;
      r_round_idx <= '0;
    end else if (w_load) begin
      r_key       <= keyIn;
      r_const     <= '0;
      r_round_idx <= '0;
    end else if (w_xfer) begin
      r_key       <= w_key_next;
      r_const     <= w_const_next;
      r_round_idx <= r_round_idx + 6'd1;
    end
  end

  // Output register: load on transfer, empty on a take with nothing new, otherwise hold.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_last_round <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid  <= 1'b1;
      r_out_data   <= w_result;
      r_last_round <= w_last;
    end else if (w_take) begin
      r_out_valid  <= 1'b0;
      r_last_round <= 1'b0;
    end
  end

  assign outValid  = r_out_valid;
  assign outData   = r_out_data;
  assign lastRound = r_last_round;
  assign roundIdx  = r_round_idx;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_gift_perm_addkey_stage.sv
// Self-checking bench for gift_perm_addkey_stage. A GIFT-128 reference
// (S-box, bit permutation, round key, constant LFSR, key schedule) built from
// plain arithmetic follows the stage cycle by cycle. SubCells outputs from the
// reference are fed back to the stage as inData.
module tb_gift_perm_addkey_stage;

  localparam int ROUNDS = 40;
  localparam int PH_IDLE  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_DRAIN = 2;
  localparam logic [63:0]  SBOX_TAB = 64'h1A4C6F392DB7508E;
  localparam logic [127:0] CT_ZERO  = 128'hCD0BD738388AD3F668B15A36CEB6FF92;
  localparam logic [5:0]   CONST_TAB [10] = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F,
                                               6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F};

  logic         clk = 1'b0;
  logic         rstN;
  logic         start;
  logic [127:0] keyIn;
  logic         inValid;
  logic [127:0] inData;
  logic         inReady;
  logic         outValid;
  logic [127:0] outData;
  logic         outReady;
  logic [5:0]   roundIdx;
  logic         lastRound;
  logic         busy;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference state.
  logic [15:0]  m_key [8];
  logic [5:0]   m_const;
  int           m_round;
  int           m_phase;
  bit           m_valid;
  bit           m_last;
  bit           m_xfer;
  logic [127:0] m_data;

  gift_perm_addkey_stage #(.ROUNDS(ROUNDS)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .start     (start),
    .keyIn     (keyIn),
    .inValid   (inValid),
    .inData    (inData),
    .inReady   (inReady),
    .outValid  (outValid),
    .outData   (outData),
    .outReady  (outReady),
    .roundIdx  (roundIdx),
    .lastRound (lastRound),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] sub_cells(input logic [127:0] x);
    logic [127:0] y;
    for (int n = 0; n < 32; n++) y[4*n +: 4] = SBOX_TAB[60 - 4 * int'(x[4*n +: 4]) +: 4];
    return y;
  endfunction

  function automatic logic [127:0] perm_bits(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int i = 0; i < 128; i++)
      y[4 * (i / 16) + 32 * ((3 * ((i % 16) / 4) + (i % 4)) % 4) + (i % 4)] = x[i];
    return y;
  endfunction

  function automatic logic [15:0] rotr16(input logic [15:0] w, input int n);
    return (w >> n) | (w << (16 - n));
  endfunction

  // One round after SubCells, using the current reference key and constant c.
  function automatic logic [127:0] model_round(input logic [127:0] x, input logic [5:0] c);
    logic [127:0] y;
    logic [31:0]  u;
    logic [31:0]  v;
    y = perm_bits(x);
    u = {m_key[5], m_key[4]};
    v = {m_key[1], m_key[0]};
    for (int i = 0; i < 32; i++) begin
      y[4*i+2] = y[4*i+2] ^ u[i];
      y[4*i+1] = y[4*i+1] ^ v[i];
    end
    for (int k = 0; k < 6; k++) y[23 - 4*k] = y[23 - 4*k] ^ c[5 - k];
    y[127] = ~y[127];
    return y;
  endfunction

  task automatic model_key_update();
    logic [15:0] k [8];
    k = m_key;
    m_key[7] = rotr16(k[1], 2);
    m_key[6] = rotr16(k[0], 12);
    for (int j = 0; j < 6; j++) m_key[j] = k[j+2];
  endtask

  task automatic model_reset();
    for (int j = 0; j < 8; j++) m_key[j] = '0;
    m_const = '0;
    m_round = 0;
    m_phase = PH_IDLE;
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_xfer  = 1'b0;
    m_data  = '0;
  endtask

  // Advance the reference by one clock given this cycle's inputs.
  task automatic model_cycle(input bit st, input bit iv, input logic [127:0] idat, input bit ordy);
    bit rdy;
    bit take;
    rdy    = (m_phase == PH_RUN) && (!m_valid || ordy);
    take   = m_valid && ordy;
    m_xfer = 1'b0;
    case (m_phase)
      PH_IDLE: if (st) begin
        for (int j = 0; j < 8; j++) m_key[j] = keyIn[16*j +: 16];
        m_const = '0;
        m_round = 0;
        m_phase = PH_RUN;
      end
      PH_RUN: if (iv && rdy) begin
        m_xfer  = 1'b1;
        m_const = {m_const[4:0], m_const[5] ^ m_const[4] ^ 1'b1};
        m_data  = model_round(idat, m_const);
        m_last  = (m_round == ROUNDS - 1);
        m_valid = 1'b1;
        model_key_update();
        m_round++;
        if (m_last) m_phase = PH_DRAIN;
      end else if (take) begin
        m_valid = 1'b0;
      end
      default: if (take) begin
        m_valid = 1'b0;
        m_phase = PH_IDLE;
      end
    endcase
  endtask

  // Drive one cycle of inputs, check inReady before the edge and outputs after it.
  task automatic step(input bit st, input bit iv, input logic [127:0] idat, input bit ordy);
    start    = st;
    inValid  = iv;
    inData   = idat;
    outReady = ordy;
    #1;
    check("inReady", 128'(inReady), 128'((m_phase == PH_RUN) && (!m_valid || ordy)));
    model_cycle(st, iv, idat, ordy);
    @(posedge clk);
    #1;
    check("outValid", 128'(outValid), 128'(m_valid));
    check("roundIdx", 128'(roundIdx), 128'(m_round));
    check("busy", 128'(busy), 128'(m_phase != PH_IDLE));
    if (m_valid) begin
      check("outData", outData, m_data);
      check("lastRound", 128'(lastRound), 128'(m_last));
    end
  endtask

  // Asynchronous reset: outputs must clear before any clock edge arrives.
  task automatic apply_reset();
    rstN = 1'b0;
    #2;
    check("rst_outValid", 128'(outValid), 128'(0));
    check("rst_lastRound", 128'(lastRound), 128'(0));
    check("rst_roundIdx", 128'(roundIdx), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_outData", outData, 128'(0));
    check("rst_inReady", 128'(inReady), 128'(0));
    model_reset();
    start   = 1'b0;
    inValid = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Run one block of ROUNDS rounds, looping results back through SubCells.
  task automatic run_block(input logic [127:0] key, input logic [127:0] pt, input bit noisy,
                           input int abort_at, input int stall_at, output logic [127:0] ct);
    logic [127:0] cur;
    int           budget;
    bit           iv;
    bit           ordy;
    bit           st;
    bit           stalled;
    keyIn   = key;
    cur     = sub_cells(pt);
    ct      = '0;
    stalled = 1'b0;
    // start together with inValid in IDLE: no transfer may happen this cycle
    step(1'b1, 1'b1, cur, 1'b1);
    budget = 0;
    while (m_phase != PH_IDLE && budget < 2000) begin
      if (abort_at >= 0 && m_round == abort_at) begin
        apply_reset();
        return;
      end
      if (m_round == stall_at && !stalled) begin
        stalled = 1'b1;
        repeat (5) step(1'b0, 1'b1, cur, 1'b0);
      end
      iv    = noisy ? ($urandom_range(0, 3) != 0) : 1'b1;
      ordy  = noisy ? ($urandom_range(0, 3) != 0) : 1'b1;
      st    = noisy ? ($urandom_range(0, 7) == 0) : 1'b0;
      keyIn = {$urandom, $urandom, $urandom, $urandom};
      step(st, iv, iv ? cur : {$urandom, $urandom, $urandom, $urandom}, ordy);
      if (m_xfer) cur = sub_cells(m_data);
      if (outValid && lastRound) ct = outData;
      budget++;
    end
    check("block_done_busy", 128'(busy), 128'(0));
  endtask

  initial begin
    logic [127:0] ct;
    logic [5:0]   cobs;
    rstN     = 1'b1;
    start    = 1'b0;
    keyIn    = '0;
    inValid  = 1'b0;
    inData   = '0;
    outReady = 1'b0;
    model_reset();
    #1;
    apply_reset();

    // Single round from key 0 on an all-ones-nibble input.
    keyIn = '0;
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, {32{4'h1}}, 1'b1);
    check("first_round_data", outData, 128'h91111111_11111111_11111111_11111119);
    check("first_round_idx", 128'(roundIdx), 128'(1));
    check("first_round_last", 128'(lastRound), 128'(0));
    apply_reset();

    // Constant sequence: key 0 and zero input leave only the constant bits.
    keyIn = '0;
    step(1'b1, 1'b0, '0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, '0, 1'b1);
      cobs = {outData[23], outData[19], outData[15], outData[11], outData[7], outData[3]};
      check("round_const", 128'(cobs), 128'(CONST_TAB[k]));
      check("const_bit127", 128'(outData[127]), 128'(1));
    end
    apply_reset();

    // Key schedule with every key word equal to 1.
    run_block({8{16'h0001}}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, -1, -1, ct);

    // Full cipher, zero key and plaintext.
    run_block('0, '0, 1'b0, -1, -1, ct);
    check("ct_zero", ct, CT_ZERO);

    // Back-pressure hold for 5 cycles mid-block, then full-rate resume.
    run_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
              1'b0, -1, 5, ct);

    // Random handshakes, stray start pulses, inValid in IDLE and DRAIN.
    for (int b = 0; b < 3; b++)
      run_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                1'b1, -1, -1, ct);

    // Abort at round 17, then a clean block must still produce the known ciphertext.
    run_block('0, '0, 1'b1, 17, -1, ct);
    run_block('0, '0, 1'b1, -1, -1, ct);
    check("ct_zero_after_abort", ct, CT_ZERO);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
